// File: rtl/lib_voq_input_buffer.sv
// Per-input virtual output queue buffer: M FIFOs selected by flit destination, popped by allocator grant.
// Optional LIB_VOQ_OCCUPANCY_EN adds o_occupancy, the registered fill count of each VOQ.
module lib_voq_input_buffer #(
    parameter int M     = 4,
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       ce,
    input  logic [WIDTH-1:0]           i_data,
    input  logic [$clog2(M)-1:0]       i_dest,
    input  logic                       i_data_val,
    output logic [0:M-1]               o_full,
    output logic [0:M-1]               o_request,
    input  logic [0:M-1]               i_grant,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_data_val,
`ifdef LIB_VOQ_OCCUPANCY_EN
    output logic [0:M-1][$clog2(DEPTH):0] o_occupancy,
`endif
    output logic                       o_overflow
);

    localparam int DEST_W = $clog2(M);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    logic [WIDTH-1:0] mem [M][DEPTH];
    logic [PTR_W-1:0] wr_ptr [M];
    logic [PTR_W-1:0] rd_ptr [M];
    logic [CNT_W-1:0] count  [M];

    logic              dest_ok;
    logic              wr_en;
    logic              ovf_nxt;
    logic              rd_en;
    logic [DEST_W-1:0] rd_idx;
    logic [M-1:0]      wr_hit;
    logic [M-1:0]      rd_hit;

    // Request/full come only from registered counts so the allocator path cannot loop back.
    always_comb begin
        for (int m = 0; m < M; m++) begin
            o_request[m] = (count[m] != '0);
            o_full[m]    = (count[m] == CNT_W'(DEPTH));
        end
    end

    generate
        if (M == (1 << DEST_W)) begin : g_dest_all_valid
            assign dest_ok = 1'b1;
        end else begin : g_dest_range
            assign dest_ok = (32'(i_dest) < M);
        end
    endgenerate

    assign wr_en   = ce && i_data_val && dest_ok && !o_full[i_dest];
    assign ovf_nxt = ce && i_data_val && dest_ok &&  o_full[i_dest];

    // Lowest-index granted non-empty VOQ wins; grants to empty VOQs fall through.
    always_comb begin
        rd_en  = 1'b0;
        rd_idx = '0;
        for (int m = 0; m < M; m++) begin
            if (!rd_en && i_grant[m] && o_request[m]) begin
                rd_en  = 1'b1;
                rd_idx = DEST_W'(m);
            end
        end
    end

    always_comb begin
        wr_hit = '0;
        rd_hit = '0;
        for (int m = 0; m < M; m++) begin
            wr_hit[m] = wr_en && (i_dest == DEST_W'(m));
            rd_hit[m] = ce && rd_en && (rd_idx == DEST_W'(m));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int m = 0; m < M; m++) begin
                wr_ptr[m] <= '0;
                rd_ptr[m] <= '0;
                count[m]  <= '0;
            end
            o_data     <= '0;
            o_data_val <= 1'b0;
            o_overflow <= 1'b0;
        end else if (ce) begin
            o_overflow <= ovf_nxt;
            o_data_val <= rd_en;
            if (rd_en) begin
                o_data <= mem[rd_idx][rd_ptr[rd_idx]];
            end
            for (int m = 0; m < M; m++) begin
                if (wr_hit[m]) begin
                    wr_ptr[m] <= wr_ptr[m] + PTR_W'(1);
                end
                if (rd_hit[m]) begin
                    rd_ptr[m] <= rd_ptr[m] + PTR_W'(1);
                end
                case ({wr_hit[m], rd_hit[m]})
                    2'b10:   count[m] <= count[m] + CNT_W'(1);
                    2'b01:   count[m] <= count[m] - CNT_W'(1);
                    default: count[m] <= count[m];
                endcase
            end
        end
    end

    // Flit storage is never reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[i_dest][wr_ptr[i_dest]] <= i_data;
        end
    end

`ifdef LIB_VOQ_OCCUPANCY_EN
    always_comb begin
        for (int m = 0; m < M; m++) begin
            o_occupancy[m] = count[m];
        end
    end
`endif

endmodule

// File: tb/tb_lib_voq_input_buffer.sv
// Bench for lib_voq_input_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_lib_voq_input_buffer;

    localparam int M     = 4;
    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             ce;
    logic [WIDTH-1:0] i_data;
    logic [1:0]       i_dest;
    logic             i_data_val;
    logic [0:M-1]     o_full;
    logic [0:M-1]     o_request;
    logic [0:M-1]     i_grant;
    logic [WIDTH-1:0] o_data;
    logic             o_data_val;
    logic             o_overflow;

    lib_voq_input_buffer #(.M(M), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ce         (ce),
        .i_data     (i_data),
        .i_dest     (i_dest),
        .i_data_val (i_data_val),
        .o_full     (o_full),
        .o_request  (o_request),
        .i_grant    (i_grant),
        .o_data     (o_data),
        .o_data_val (o_data_val),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] q [M][$];
    logic [WIDTH-1:0] exp_data = '0;
    logic             exp_val  = 1'b0;
    logic             exp_ovf  = 1'b0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [0:M-1] rq;
        logic [0:M-1] fl;
        for (int m = 0; m < M; m++) begin
            rq[m] = (q[m].size() != 0);
            fl[m] = (q[m].size() == DEPTH);
        end
        chk_eq("request", 64'(o_request), 64'(rq));
        chk_eq("full", 64'(o_full), 64'(fl));
        chk_eq("data_val", 64'(o_data_val), 64'(exp_val));
        chk_eq("data", 64'(o_data), 64'(exp_data));
        chk_eq("overflow", 64'(o_overflow), 64'(exp_ovf));
    endtask

    task automatic model_clear();
        for (int m = 0; m < M; m++) q[m].delete();
        exp_data = '0;
        exp_val  = 1'b0;
        exp_ovf  = 1'b0;
    endtask

    // Drive one cycle, advance the model, then compare after the edge.
    task automatic cycle(input logic c, input logic v, input logic [1:0] d,
                         input logic [WIDTH-1:0] dat, input logic [0:M-1] g);
        int  served;
        bit  push_ok;
        ce = c; i_data_val = v; i_dest = d; i_data = dat; i_grant = g;
        if (c) begin
            served = -1;
            for (int m = 0; m < M; m++)
                if (served < 0 && g[m] && q[m].size() > 0) served = m;
            push_ok = v && (q[d].size() < DEPTH);
            exp_ovf = v && (q[d].size() == DEPTH);
            if (served >= 0) begin
                exp_data = q[served].pop_front();
                exp_val  = 1'b1;
            end else begin
                exp_val = 1'b0;
            end
            if (push_ok) q[d].push_back(dat);
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    initial begin
        reset_n = 1'b0; ce = 1'b0; i_data = '0; i_dest = '0; i_data_val = 1'b0; i_grant = '0;
        #12;
        chk_eq("rst_request", 64'(o_request), 64'h0);
        chk_eq("rst_data_val", 64'(o_data_val), 64'h0);
        #10 reset_n = 1'b1;
        model_clear();

        // Two flits to VOQ 2, popped in order.
        cycle(1, 1, 2, 32'hA1, 4'b0000);
        chk_eq("t2_request", 64'(o_request), 64'(4'b0010));
        cycle(1, 1, 2, 32'hA2, 4'b0000);
        cycle(1, 0, 0, 32'h0, 4'b0010);
        chk_eq("t2_first", 64'(o_data), 64'hA1);
        cycle(1, 0, 0, 32'h0, 4'b0010);
        chk_eq("t2_second", 64'(o_data), 64'hA2);
        chk_eq("t2_empty", 64'(o_request), 64'(4'b0000));
        cycle(1, 0, 0, 32'h0, 4'b0000);
        chk_eq("t2_val_low", 64'(o_data_val), 64'h0);

        // Fill VOQ 1, then overflow it.
        for (int i = 0; i < DEPTH; i++) cycle(1, 1, 1, 32'h100 + 32'(i), 4'b0000);
        chk_eq("t3_full", 64'(o_full), 64'(4'b0100));
        cycle(1, 1, 1, 32'hDEAD, 4'b0000);
        chk_eq("t3_ovf", 64'(o_overflow), 64'h1);
        cycle(1, 0, 0, 32'h0, 4'b0000);
        chk_eq("t3_ovf_pulse", 64'(o_overflow), 64'h0);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1, 0, 0, 32'h0, 4'b0100);
            chk_eq("t3_drain", 64'(o_data), 64'(32'h100 + 32'(i)));
        end

        // Simultaneous write and pop on VOQ 3.
        cycle(1, 1, 3, 32'hB0, 4'b0000);
        cycle(1, 1, 3, 32'hB1, 4'b0000);
        cycle(1, 1, 3, 32'h55, 4'b0001);
        chk_eq("t4_head", 64'(o_data), 64'hB0);
        cycle(1, 0, 0, 32'h0, 4'b0001);
        cycle(1, 0, 0, 32'h0, 4'b0001);
        chk_eq("t4_last", 64'(o_data), 64'h55);

        // Pointer wrap on VOQ 0.
        for (int i = 0; i < 10; i++) begin
            cycle(1, 1, 0, 32'(i), 4'b0000);
            cycle(1, 0, 0, 32'h0, 4'b1000);
            chk_eq("t5_order", 64'(o_data), 64'(i));
        end

        // Clock enable hold, grant to empty VOQ, multi-hot grant.
        cycle(1, 1, 0, 32'hC0, 4'b0000);
        cycle(1, 1, 0, 32'hC1, 4'b0000);
        cycle(1, 1, 1, 32'hC2, 4'b0000);
        cycle(1, 1, 0, 32'hC3, 4'b1000);
        chk_eq("t6_pop", 64'(o_data), 64'hC0);
        cycle(0, 1, 0, 32'hEE, 4'b1000);
        chk_eq("t6_ce_val", 64'(o_data_val), 64'h1);
        chk_eq("t6_ce_data", 64'(o_data), 64'hC0);
        cycle(1, 0, 0, 32'h0, 4'b0010);
        chk_eq("t6_empty_grant", 64'(o_data_val), 64'h0);
        cycle(1, 0, 0, 32'h0, 4'b1100);
        chk_eq("t6_multihot", 64'(o_data), 64'hC1);

        // Asynchronous reset with flits still queued.
        cycle(1, 1, 2, 32'hF0, 4'b0000);
        cycle(1, 1, 3, 32'hF1, 4'b0000);
        #2 reset_n = 1'b0;
        #1;
        model_clear();
        chk_eq("t1_request", 64'(o_request), 64'h0);
        chk_eq("t1_full", 64'(o_full), 64'h0);
        chk_eq("t1_data", 64'(o_data), 64'h0);
        chk_eq("t1_data_val", 64'(o_data_val), 64'h0);
        chk_eq("t1_overflow", 64'(o_overflow), 64'h0);
        #3 reset_n = 1'b1;
        cycle(1, 0, 0, 32'h0, 4'b1111);
        chk_eq("t1_after", 64'(o_request), 64'(4'b0000));

        // Random traffic, including overflow attempts and multi-hot grants.
        for (int n = 0; n < 2000; n++) begin
            cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 6),
                  2'($urandom_range(0, 3)), $urandom(),
                  ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'b0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
